// File: rtl/imag_lbuf_pkg.sv
// Shared types for the image line-buffer controller.
package imag_lbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    LINES = 2'd2
  } lbuf_state_e;

  typedef struct packed {
    logic tuser;
    logic tlast;
    logic first;
  } lbuf_flags_t;

endpackage

// File: rtl/imag_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module imag_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

  localparam int WD_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WD_CNT = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WD_PTR-1:0] wr_q, rd_q;
  logic [WD_CNT-1:0] cnt_q;
  logic              do_push, do_pop;

  function automatic logic [WD_PTR-1:0] nxt(
    input logic [WD_PTR-1:0] p
  );
    return (p == WD_PTR'(DEPTH - 1)) ? '0 : p + WD_PTR'(1);
  endfunction

  assign do_push = push_i && (cnt_q != WD_CNT'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + WD_CNT'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - WD_CNT'(1);
    end
  end

  assign data_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/imag_line_buf_ctrl.sv
// Line-buffer controller: writes the current line via BRAM port A, reads the previous line on port B.
// Define IMAG_LBUF_LEN_CHK_EN to enable sticky line-length mismatch detection on o_err_len.
module imag_line_buf_ctrl
  import imag_lbuf_pkg::*;
#(
  parameter int NB_BRAM_DLY = 2,
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_PIX      = 8
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [WD_PIX-1:0]      s_axis_tdata,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   m_bram_ena,
  output logic                   m_bram_wea,
  output logic [WD_BRAM_ADR-1:0] m_bram_addra,
  output logic [WD_PIX-1:0]      m_bram_dina,
  output logic                   m_bram_enb,
  output logic [WD_BRAM_ADR-1:0] m_bram_addrb,
  input  logic [WD_PIX-1:0]      m_bram_doutb,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [2*WD_PIX-1:0]    m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tfirst,
  output logic                   o_err_ovf,
  output logic                   o_err_len
);

  localparam int NB_OUT_FIFO = NB_BRAM_DLY + 2;
  localparam int WD_CNT      = $clog2(NB_OUT_FIFO + 1);
  localparam int WD_FIFO     = 2 * WD_PIX + 3;
  localparam logic [WD_BRAM_ADR-1:0] COL_MAX = '1;

  typedef struct packed {
    logic [WD_PIX-1:0] cur;
    lbuf_flags_t       flg;
  } lbuf_sb_t;

  lbuf_state_e            state_q, state_d;
  logic [WD_BRAM_ADR-1:0] col_q, col_d;
  logic                   ovf_q, ovf_d;
  logic                   rdy_en_q;
  logic [NB_BRAM_DLY-1:0] vld_q;
  lbuf_sb_t               sb_q [NB_BRAM_DLY];
  lbuf_sb_t               sb_in, sb_out;
  logic [WD_CNT-1:0]      fifo_cnt, inflight;
  logic [WD_CNT:0]        credits;
  logic                   acc, take, is_first;
  logic [WD_BRAM_ADR-1:0] addr;
  logic [WD_PIX-1:0]      prev_pix;
  logic                   push, pop;
  logic [WD_FIFO-1:0]     fifo_din, fifo_dout;

  // Credits count both queued and in-flight beats so a push never finds the FIFO full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NB_BRAM_DLY; i++)
      inflight = inflight + WD_CNT'(vld_q[i]);
  end

  assign credits = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign s_axis_tready = rdy_en_q &&
    (credits < (WD_CNT + 1)'(NB_OUT_FIFO));
  assign acc      = s_axis_tvalid && s_axis_tready;
  assign take     = acc && (s_axis_tuser || state_q != IDLE);
  assign is_first = s_axis_tuser || state_q == FIRST;
  assign addr     = s_axis_tuser ? '0 : col_q;

  assign m_bram_ena   = take;
  assign m_bram_wea   = take;
  assign m_bram_enb   = take;
  assign m_bram_addra = take ? addr : '0;
  assign m_bram_addrb = m_bram_addra;
  assign m_bram_dina  = take ? s_axis_tdata : '0;

  always_comb begin
    sb_in           = '0;
    sb_in.cur       = s_axis_tdata;
    sb_in.flg.tuser = s_axis_tuser;
    sb_in.flg.tlast = s_axis_tlast;
    sb_in.flg.first = is_first;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    ovf_d   = ovf_q;
    if (take) begin
      unique case (1'b1)
        s_axis_tuser:
          state_d = s_axis_tlast ? LINES : FIRST;
        !s_axis_tuser && s_axis_tlast && (state_q == FIRST):
          state_d = LINES;
        default: ;
      endcase
      if (s_axis_tlast) begin
        col_d = '0;
      end else if (addr == COL_MAX) begin
        col_d = '0;
        ovf_d = 1'b1;
      end else begin
        col_d = addr + WD_BRAM_ADR'(1);
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q  <= IDLE;
      col_q    <= '0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Sideband rides alongside the BRAM read so it meets doutb at the push.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      vld_q <= '0;
      for (int i = 0; i < NB_BRAM_DLY; i++)
        sb_q[i] <= '0;
    end else begin
      vld_q[0] <= take;
      sb_q[0]  <= sb_in;
      for (int i = 1; i < NB_BRAM_DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sb_q[i]  <= sb_q[i-1];
      end
    end
  end

  assign sb_out   = sb_q[NB_BRAM_DLY-1];
  assign push     = vld_q[NB_BRAM_DLY-1];
  assign prev_pix = sb_out.flg.first ? '0 : m_bram_doutb;
  assign fifo_din = {prev_pix, sb_out.cur, sb_out.flg.tuser,
                     sb_out.flg.tlast, sb_out.flg.first};

  imag_sync_fifo #(
    .DEPTH (NB_OUT_FIFO),
    .WIDTH (WD_FIFO)
  ) u_out_fifo (
    .clk_i  (i_sys_clk),
    .rst_ni (i_sys_resetn),
    .push_i (push),
    .data_i (fifo_din),
    .pop_i  (pop),
    .data_o (fifo_dout),
    .cnt_o  (fifo_cnt)
  );

  assign m_axis_tvalid = fifo_cnt != '0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? fifo_dout[WD_FIFO-1:3] : '0;
  assign m_axis_tuser  = m_axis_tvalid && fifo_dout[2];
  assign m_axis_tlast  = m_axis_tvalid && fifo_dout[1];
  assign m_axis_tfirst = m_axis_tvalid && fifo_dout[0];
  assign o_err_ovf     = ovf_q;

`ifdef IMAG_LBUF_LEN_CHK_EN
  logic [WD_BRAM_ADR:0] len_q, len_d, cur_len;
  logic                 len_err_q, len_err_d;

  assign cur_len = {1'b0, addr} + (WD_BRAM_ADR + 1)'(1);

  always_comb begin
    len_d     = len_q;
    len_err_d = len_err_q;
    if (take && s_axis_tlast) begin
      if (is_first)
        len_d = cur_len;
      else if (cur_len != len_q)
        len_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end

  assign o_err_len = len_err_q;
`else
  assign o_err_len = 1'b0;
`endif

endmodule

// File: tb/tb_imag_line_buf_ctrl.sv
// Bench for imag_line_buf_ctrl: beat-level reference model, BRAM model, per-cycle compare.
module tb_imag_line_buf_ctrl;

  localparam int NB = 2;
  localparam int WA = 8;
  localparam int WP = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        user;
    logic        last;
    logic        first;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid, s_tready, s_tuser, s_tlast;
  logic [WP-1:0] s_tdata;
  logic          ena, wea, enb;
  logic [WA-1:0] addra, addrb;
  logic [WP-1:0] dina, doutb;
  logic          m_tvalid, m_tready, m_tuser, m_tlast, m_tfirst;
  logic [15:0]   m_tdata;
  logic          err_ovf, err_len;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;

  beat_t exp_q[$];
  beat_t log_q[$];
  beat_t got_b, exp_b;

  bit           m_started, m_first, m_ovf, m_lenerr;
  int           m_col, m_len;
  logic [7:0]   m_mem [256];

  logic [WP-1:0] bram [256];
  logic [WP-1:0] rd_pipe [NB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imag_line_buf_ctrl #(
    .NB_BRAM_DLY (NB),
    .WD_BRAM_ADR (WA),
    .WD_PIX      (WP)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_resetn  (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_bram_ena    (ena),
    .m_bram_wea    (wea),
    .m_bram_addra  (addra),
    .m_bram_dina   (dina),
    .m_bram_enb    (enb),
    .m_bram_addrb  (addrb),
    .m_bram_doutb  (doutb),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tfirst (m_tfirst),
    .o_err_ovf     (err_ovf),
    .o_err_len     (err_len)
  );

  // Read-first dual-port BRAM with NB clocks of read latency.
  always @(posedge clk) begin
    if (enb) rd_pipe[0] <= bram[addrb];
    if (ena && wea) bram[addra] <= dina;
    for (int i = 1; i < NB; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign doutb = rd_pipe[NB-1];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_started = 0;
    m_first   = 0;
    m_col     = 0;
    m_ovf     = 0;
    m_lenerr  = 0;
    m_len     = 0;
  endtask

  task automatic model_accept(input logic [7:0] pix, input bit user,
                              input bit last);
    bit fst;
    int c;
    beat_t b;
    if (user) begin
      m_started = 1;
      m_first   = 1;
      m_col     = 0;
    end else if (!m_started) begin
      return;
    end
    fst = m_first;
    c   = m_col;
    b.data  = {fst ? 8'h00 : m_mem[c], pix};
    b.user  = user;
    b.last  = last;
    b.first = fst;
    exp_q.push_back(b);
    m_mem[c] = pix;
    if (last) begin
      if (fst) m_len = c + 1;
      else if (c + 1 != m_len) m_lenerr = 1;
      m_col   = 0;
      m_first = 0;
    end else if (c == 255) begin
      m_col = 0;
      m_ovf = 1;
    end else begin
      m_col = c + 1;
    end
  endtask

  // Output checker: beats are compared in the cycle the handshake completes.
  always @(negedge clk) begin
    if (ready_mode == 0)      m_tready = 1'b1;
    else if (ready_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
    else                      m_tready = 1'b0;
    #1;
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        got_b = '{m_tdata, m_tuser, m_tlast, m_tfirst};
        log_q.push_back(got_b);
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("m_axis_beat", 32'(got_b), 32'(exp_b));
        end
      end
      check("o_err_ovf", 32'(err_ovf), 32'(m_ovf));
`ifdef IMAG_LBUF_LEN_CHK_EN
      check("o_err_len", 32'(err_len), 32'(m_lenerr));
`else
      check("o_err_len", 32'(err_len), 32'd0);
`endif
    end
  end

  task automatic send_beat(input logic [7:0] pix, input bit user,
                           input bit last, input bit gaps);
    int tries = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    forever begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = pix;
      s_tuser  = user;
      s_tlast  = last;
      #1;
      if (s_tready) begin
        model_accept(pix, user, last);
        break;
      end
      tries++;
      if (tries > 300) begin
        check("accept_timeout", 32'(tries), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic send_line(input int row, input int width, input bit sof,
                           input bit gaps, input int base, input bit rnd);
    for (int c = 0; c < width; c++)
      send_beat(rnd ? 8'($urandom) : 8'(base + row * 16 + c),
                sof && c == 0, c == width - 1, gaps);
  endtask

  task automatic send_frame(input int h, input int w, input int base,
                            input bit gaps, input bit rnd);
    for (int r = 0; r < h; r++)
      send_line(r, w, r == 0, gaps, base, rnd);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_bram_ena", 32'({ena, wea, enb}), 32'd0);
    check("rst_errs", 32'({err_ovf, err_len}), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, acc, k, h, w;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    do_reset();

    // 3x4 frame, pix = row*16+col
    idx = log_q.size();
    send_frame(3, 4, 0, 0, 0);
    drain();
    check("t1_count", 32'(log_q.size() - idx), 32'd12);
    check("t1_b0", 32'(log_q[idx]), 32'({16'h0000, 1'b1, 1'b0, 1'b1}));
    check("t1_b3", 32'(log_q[idx+3]), 32'({16'h0003, 1'b0, 1'b1, 1'b1}));
    check("t1_b5", 32'(log_q[idx+5]), 32'({16'h0111, 1'b0, 1'b0, 1'b0}));
    check("t1_b11", 32'(log_q[idx+11]), 32'({16'h1323, 1'b0, 1'b1, 1'b0}));

    // backpressure mid-line1
    idx = log_q.size();
    send_line(0, 12, 1, 0, 0, 0);
    send_beat(8'd16, 0, 0, 0);
    send_beat(8'd17, 0, 0, 0);
    drain();
    ready_mode = 2;
    acc = 0;
    k   = 2;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 8'(16 + k);
      s_tuser  = 1'b0;
      s_tlast  = (k == 11);
      #1;
      if (s_tready) begin
        model_accept(8'(16 + k), 0, k == 11);
        k++;
        acc++;
      end
      @(posedge clk);
      #1 s_tvalid = 1'b0;
    end
    check("t2_accepts", 32'(acc), 32'd4);
    ready_mode = 0;
    for (int c = k; c < 12; c++)
      send_beat(8'(16 + c), 0, c == 11, 0);
    send_line(2, 12, 0, 0, 0, 0);
    drain();
    check("t2_count", 32'(log_q.size() - idx), 32'd36);
    for (int c = 0; c < 12; c++)
      check("t2_order", 32'(log_q[idx+12+c].data), 32'({8'(c), 8'(16 + c)}));

    // 257-pixel line overflows the column counter
    for (int i = 0; i <= 256; i++) begin
      send_beat(8'(i), i == 0, i == 256, 0);
      if (i == 254) check("t3_ovf_before", 32'(err_ovf), 32'd0);
      if (i == 255) check("t3_ovf_set", 32'(err_ovf), 32'd1);
    end
    send_line(0, 4, 0, 0, 100, 0);
    drain();
    check("t3_ovf_sticky", 32'(err_ovf), 32'd1);

    // reset in the middle of line 2, then junk before SOF
    send_frame(2, 6, 64, 0, 0);
    send_line(2, 3, 0, 0, 64, 0);
    do_reset();
    idx = log_q.size();
    for (int j = 0; j < 5; j++)
      send_beat(8'(8'hA0 + j), 0, j == 2, 0);
    repeat (10) @(negedge clk);
    check("t4_no_output", 32'(log_q.size() - idx), 32'd0);
    send_frame(3, 4, 128, 0, 0);
    drain();
    check("t4_count", 32'(log_q.size() - idx), 32'd12);
    check("t4_first", 32'(log_q[idx]), 32'({16'h0080, 1'b1, 1'b0, 1'b1}));

    // line lengths 4,4,3
    send_line(0, 4, 1, 0, 0, 0);
    send_line(1, 4, 0, 0, 0, 0);
    send_line(2, 3, 0, 0, 0, 0);
    drain();
`ifdef IMAG_LBUF_LEN_CHK_EN
    check("t6_len_err", 32'(err_len), 32'd1);
`else
    check("t6_len_err", 32'(err_len), 32'd0);
`endif

    // random frames with random gaps and output backpressure
    ready_mode = 1;
    for (int f = 0; f < 8; f++) begin
      h = $urandom_range(1, 4);
      w = $urandom_range(1, 10);
      send_frame(h, w, 0, 1, 1);
    end
    ready_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
